// File: rtl/alu_shift_unit.sv
// Iterative shift/rotate unit that sits beside the ALU.
// The operand is shifted STEP bits per cycle. Result and N/Z/C/V flags are
// published together with a one-cycle done pulse.
// busy/done are registered views of the FSM state, so they trail it by one
// edge. The internal DONE state therefore precedes the visible done cycle, and
// a new request is taken in the IDLE cycle that carries the done pulse.
module alu_shift_unit #(
    parameter int W    = 16,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags
);

    // Wide enough to hold the amount W itself.
    localparam int RW = $clog2(W + 1);
    localparam logic [RW-1:0] W_AMT    = RW'(W);
    localparam logic [RW-1:0] STEP_AMT = RW'(STEP);
    localparam logic [W-1:0]  W_OPB    = W'(W);

    localparam logic [4:0] OP_LSL = 5'b00001;
    localparam logic [4:0] OP_LSR = 5'b00010;
    localparam logic [4:0] OP_ASR = 5'b00011;
    localparam logic [4:0] OP_ROL = 5'b00100;
    localparam logic [4:0] OP_ROR = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [4:0] op);
        logic ok;
        case (op)
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Shifts saturate at W. Rotates wrap modulo W. operandB is always unsigned.
    function automatic logic [RW-1:0] eff_amount(input logic [4:0] op, input logic [W-1:0] b);
        logic [RW-1:0] amt;
        if (op == OP_ROL || op == OP_ROR) begin
            amt = RW'(b % W_OPB);
        end else if (b >= W_OPB) begin
            amt = W_AMT;
        end else begin
            amt = RW'(b);
        end
        return amt;
    endfunction

    // One partial shift by s bits (1 <= s <= W; s < W for rotates).
    function automatic logic [W-1:0] shift_step(input logic [4:0] op, input logic [W-1:0] data,
                                                input logic [RW-1:0] s);
        logic [W-1:0] r;
        case (op)
            OP_LSL:  r = data << s;
            OP_LSR:  r = data >> s;
            OP_ASR:  r = $unsigned($signed(data) >>> s);
            OP_ROL:  r = (data << s) | (data >> (W_AMT - s));
            OP_ROR:  r = (data >> s) | (data << (W_AMT - s));
            default: r = data;
        endcase
        return r;
    endfunction

    // Last bit leaving the word during a partial shift by s bits.
    function automatic logic step_carry(input logic [4:0] op, input logic [W-1:0] data,
                                        input logic [RW-1:0] s);
        logic [W-1:0] t;
        case (op)
            OP_LSL:         t = data >> (W_AMT - s);
            OP_LSR, OP_ASR: t = data >> (s - RW'(1));
            default:        t = {W{1'b0}};
        endcase
        return t[0];
    endfunction

    // Carry flag of a completed, non-zero-amount operation.
    function automatic logic final_carry(input logic [4:0] op, input logic [W-1:0] res,
                                         input logic sc);
        logic c;
        case (op)
            OP_ROR:                 c = res[W-1];
            OP_ROL:                 c = res[0];
            OP_LSL, OP_LSR, OP_ASR: c = sc;
            default:                c = 1'b0;
        endcase
        return c;
    endfunction

    state_e        state_q, state_d;
    logic [4:0]    op_q, op_d;
    logic [W-1:0]  data_q, data_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          carry_q, carry_d;
    logic          ill_q, ill_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  result_q, result_d;
    logic [3:0]    flags_q, flags_d;

    logic [RW-1:0] n_s;
    logic [RW-1:0] step_s;
    logic [RW-1:0] rem_left_s;
    logic [W-1:0]  shifted_s;
    logic          step_c_s;

    // Datapath for the current cycle: amount decode and one partial shift.
    always_comb begin
        n_s        = eff_amount(alu_op, operandB);
        step_s     = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        rem_left_s = rem_q - step_s;
        shifted_s  = shift_step(op_q, data_q, step_s);
        step_c_s   = step_carry(op_q, data_q, step_s);
    end

    // Next-state logic of the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        rem_d    = rem_q;
        carry_d  = carry_q;
        ill_d    = ill_q;
        busy_d   = (state_q == ST_SHIFT);
        done_d   = (state_q == ST_DONE);
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = alu_op;
                    data_d  = operandA;
                    carry_d = 1'b0;
                    ill_d   = ~op_legal(alu_op);
                    if (!op_legal(alu_op) || (n_s == {RW{1'b0}})) begin
                        rem_d   = {RW{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = n_s;
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d = shifted_s;
                rem_d  = rem_left_s;
                if (rem_left_s == {RW{1'b0}}) begin
                    carry_d = final_carry(op_q, shifted_s, step_c_s);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // Publish on the same edge that raises done.
                result_d = data_q;
                flags_d  = {data_q[W-1], (data_q == {W{1'b0}}), carry_q, ill_q};
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 5'b00000;
            data_q   <= {W{1'b0}};
            rem_q    <= {RW{1'b0}};
            carry_q  <= 1'b0;
            ill_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {W{1'b0}};
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            carry_q  <= carry_d;
            ill_q    <= ill_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign resultAccumulator = result_q;
    assign flags             = flags_q;

endmodule

// File: tb/tb_alu_shift_unit.sv
// Scoreboard bench for alu_shift_unit: a STEP=1 and a STEP=4 instance.
module tb_alu_shift_unit;

    localparam logic [4:0] OP_LSL = 5'b00001;
    localparam logic [4:0] OP_LSR = 5'b00010;
    localparam logic [4:0] OP_ASR = 5'b00011;
    localparam logic [4:0] OP_ROL = 5'b00100;
    localparam logic [4:0] OP_ROR = 5'b00101;
    localparam logic [4:0] OP_BAD = 5'b11111;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
        int          bsnap;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start1, start4;
    logic [4:0]  op1, op4;
    logic [15:0] a1, b1, a4, b4;
    logic        busy1, done1, busy4, done4;
    logic [15:0] res1, res4;
    logic [3:0]  flg1, flg4;

    int   cyc = 0;
    int   btot1 = 0;
    int   btot4 = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q1[$];
    exp_t q4[$];

    alu_shift_unit #(.W(16), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .alu_op(op1),
        .operandA(a1), .operandB(b1), .busy(busy1), .done(done1),
        .resultAccumulator(res1), .flags(flg1)
    );

    alu_shift_unit #(.W(16), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .alu_op(op4),
        .operandA(a4), .operandB(b4), .busy(busy4), .done(done4),
        .resultAccumulator(res4), .flags(flg4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [15:0] r,
                         input logic [3:0] f, input int bnow);
        check($sformatf("%s_%0d_result", tag, e.id), 32'(r), 32'(e.res));
        check($sformatf("%s_%0d_flags", tag, e.id), 32'(f), 32'(e.flg));
        check($sformatf("%s_%0d_latency", tag, e.id), cyc - e.acc, e.lat);
        check($sformatf("%s_%0d_busy_cycles", tag, e.id), bnow - e.bsnap, e.lat - 1);
    endtask

    // Monitor for the STEP=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (busy1) btot1 = btot1 + 1;
        if (done1) begin
            check("s1_busy_in_done", 32'(busy1), 32'd0);
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL s1_unexpected_done: got a done pulse, expected none pending");
            end else begin
                e = q1.pop_front();
                score("s1", e, res1, flg1, btot1);
            end
        end
    end

    // Monitor for the STEP=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (busy4) btot4 = btot4 + 1;
        if (done4) begin
            check("s4_busy_in_done", 32'(busy4), 32'd0);
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL s4_unexpected_done: got a done pulse, expected none pending");
            end else begin
                e = q4.pop_front();
                score("s4", e, res4, flg4, btot4);
            end
        end
    end

    task automatic drive(input int sel, input logic s, input logic [4:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (sel == 1) begin
            start1 = s; op1 = op; a1 = a; b1 = b;
        end else begin
            start4 = s; op4 = op; a4 = a; b4 = b;
        end
    endtask

    task automatic push(input int sel, input int id, input logic [15:0] er,
                        input logic [3:0] ef, input int lat);
        exp_t e;
        e.id  = id;
        e.res = er;
        e.flg = ef;
        e.lat = lat;
        e.acc = cyc;
        if (sel == 1) begin
            e.bsnap = btot1;
            q1.push_back(e);
        end else begin
            e.bsnap = btot4;
            q4.push_back(e);
        end
    endtask

    // One request: start high for one edge, then operands scrambled.
    task automatic issue(input int sel, input int id, input logic [4:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [3:0] ef, input int lat);
        @(posedge clk); #1;
        drive(sel, 1'b1, op, a, b);
        @(posedge clk); #1;
        push(sel, id, er, ef, lat);
        drive(sel, 1'b0, op, 16'hA5A5, 16'h0003);
    endtask

    task automatic drain(input int sel);
        int k;
        k = 0;
        while (((sel == 1) ? q1.size() : q4.size()) != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("drain_s%0d_pending", sel), 32'((sel == 1) ? q1.size() : q4.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit got;
        rst = 1'b1;
        drive(1, 1'b0, 5'b00000, 16'h0000, 16'h0000);
        drive(4, 1'b0, 5'b00000, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset_done", 32'(done1), 32'd0);
        check("reset_result", 32'(res1), 32'd0);
        check("reset_flags", 32'(flg1), 32'd0);
        check("reset_result_s4", 32'(res4), 32'd0);

        // STEP=1 directed vectors: {N,Z,C,V}
        issue(1, 1, OP_LSR, 16'h0010, 16'h0004, 16'h0001, 4'b0000, 5);  drain(1);
        issue(1, 2, OP_LSR, 16'hFFF3, 16'hFFFD, 16'h0000, 4'b0110, 17); drain(1);
        issue(1, 3, OP_ASR, 16'hFFF3, 16'h0002, 16'hFFFC, 4'b1010, 3);  drain(1);
        issue(1, 4, OP_ROR, 16'h8001, 16'h0001, 16'hC000, 4'b1010, 2);  drain(1);
        issue(1, 5, OP_ROL, 16'h8001, 16'h0011, 16'h0003, 4'b0010, 2);  drain(1);
        issue(1, 6, OP_LSR, 16'h0009, 16'h0000, 16'h0009, 4'b0000, 1);  drain(1);
        issue(1, 7, OP_BAD, 16'h1234, 16'h0005, 16'h1234, 4'b0001, 1);  drain(1);
        issue(1, 8, OP_LSL, 16'h1801, 16'h0004, 16'h8010, 4'b1010, 5);  drain(1);
        issue(1, 9, OP_ROR, 16'h0001, 16'h0010, 16'h0001, 4'b0000, 1);  drain(1);

        // start pulsed while busy must be ignored
        issue(1, 10, OP_LSR, 16'h00FF, 16'h0004, 16'h000F, 4'b0010, 5);
        @(posedge clk); #1;
        drive(1, 1'b1, OP_BAD, 16'h7777, 16'h0000);
        @(posedge clk); #1;
        drive(1, 1'b0, OP_BAD, 16'h7777, 16'h0000);
        drain(1);

        // start held through the operation is taken in the done cycle
        @(posedge clk); #1;
        drive(1, 1'b1, OP_LSL, 16'h0001, 16'h0003);
        @(posedge clk); #1;
        push(1, 11, 16'h0008, 4'b0000, 4);
        drive(1, 1'b1, OP_ASR, 16'h8000, 16'h0014);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done1) got = 1'b1;
        end
        check("b2b_first_done_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        push(1, 12, 16'hFFFF, 4'b1010, 17);
        drive(1, 1'b0, OP_ASR, 16'h1111, 16'h0001);
        drain(1);

        // reset in the middle of a shift discards the request
        @(posedge clk); #1;
        drive(1, 1'b1, OP_LSR, 16'hFF00, 16'h0008);
        @(posedge clk); #1;
        drive(1, 1'b0, OP_LSR, 16'hFF00, 16'h0008);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midop_busy_before_reset", 32'(busy1), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midop_reset_busy", 32'(busy1), 32'd0);
        check("midop_reset_done", 32'(done1), 32'd0);
        check("midop_reset_result", 32'(res1), 32'd0);
        check("midop_reset_flags", 32'(flg1), 32'd0);
        repeat (20) @(posedge clk);

        // STEP=4 directed vectors
        issue(4, 1, OP_LSL, 16'h0001, 16'h000F, 16'h8000, 4'b1000, 5); drain(4);
        issue(4, 2, OP_LSL, 16'h0009, 16'h0001, 16'h0012, 4'b0000, 2); drain(4);
        issue(4, 3, OP_LSL, 16'h8000, 16'h0010, 16'h0000, 4'b0100, 5); drain(4);
        issue(4, 4, OP_LSR, 16'hFFF3, 16'h0006, 16'h03FF, 4'b0010, 3); drain(4);
        issue(4, 5, OP_ROR, 16'h1234, 16'h0008, 16'h3412, 4'b0000, 3); drain(4);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
